// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index, scoreboard entry, halt state
package cpu_types_pkg;

  localparam int REG_BITS = 5;

  typedef logic [REG_BITS-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    logic     wen;
    logic     load;
    regbits_t wsel;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_t;

  // True when entry e will write architectural register r (r0 never counts).
  function automatic logic entry_writes(sb_entry_t e, regbits_t r);
    return e.valid && e.wen && (e.wsel == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-producer priority matcher for one source operand
module fwd_match
  import cpu_types_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int FSW        = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] ents,
  input  regbits_t              src,
  output logic [FSW-1:0]        fsel,
  output logic                  load_use
);

  // Walk oldest to youngest so the youngest matching entry has the last word.
  always_comb begin
    fsel     = '0;
    load_use = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entry_writes(ents[k], src)) begin
        if (ents[k].load && (k < LOAD_STAGE)) begin
          fsel     = '0;
          load_use = 1'b1;
        end else begin
          fsel     = FSW'(k + 1);
          load_use = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-flight write tracking, forwarding select, load-use stall and halt drain
module pipeline_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int NREGS      = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        adv,
  input  logic                        d_valid,
  input  regbits_t                    d_rs,
  input  regbits_t                    d_rt,
  input  logic                        d_wen,
  input  logic                        d_load,
  input  logic                        d_halt,
  input  regbits_t                    d_wsel,
  input  logic                        flush,
  output logic                        stall,
  output logic [$clog2(DEPTH+1)-1:0]  fsel_a,
  output logic [$clog2(DEPTH+1)-1:0]  fsel_b,
  output logic [NREGS-1:0]            busy,
  output logic                        halted
);

  localparam int FSW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] ent_q, ent_d;
  halt_state_t           state_q, state_d;
  sb_entry_t             new_ent;
  logic                  lu_a, lu_b;
  logic                  accept;
  logic                  any_next_valid;

  fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FSW(FSW)) u_match_rs (
    .ents     (ent_q),
    .src      (d_rs),
    .fsel     (fsel_a),
    .load_use (lu_a)
  );

  fwd_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FSW(FSW)) u_match_rt (
    .ents     (ent_q),
    .src      (d_rt),
    .fsel     (fsel_b),
    .load_use (lu_b)
  );

  // Outside RUN nothing may issue, so any real decode instruction is held.
  always_comb begin
    stall = 1'b0;
    if (state_q != ST_RUN) stall = d_valid;
    else                   stall = d_valid & (lu_a | lu_b);
  end

  assign accept = d_valid & ~flush & ~stall & (state_q == ST_RUN);

  always_comb begin
    new_ent = '0;
    if (accept) begin
      new_ent.valid = 1'b1;
      new_ent.wen   = d_wen;
      new_ent.load  = d_load;
      new_ent.wsel  = d_wsel;
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (adv) begin
      ent_d[0] = new_ent;
      for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
    end
  end

  always_comb begin
    any_next_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_next_valid = any_next_valid | ent_d[k].valid;
  end

  // Drain completion looks at the post-update entries so HALTED lands on the
  // same edge that retires the HALT itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (adv && accept && d_halt) state_d = ST_DRAIN;
      ST_DRAIN:  if (!any_next_valid)        state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ent_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      ent_q   <= ent_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_q[k].valid && ent_q[k].wen) busy[ent_q[k].wsel] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign halted = (state_q == ST_HALTED);

endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: number of in-flight stages tracked after decode (EX..WB); legal range 2-8.
REQ-002 Parameter LOAD_STAGE, default 1: first entry index at which load data is forwardable.
REQ-003 Parameter NREGS, default 32: architectural register count; register 0 is hardwired zero.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 adv  in  1  pipeline advances this cycle (all latches enabled).
REQ-007 d_valid  in  1  decode holds a real instruction.
REQ-008 d_rs, d_rt  in  regbits_t  decode source registers.
REQ-009 d_wen, d_load, d_halt  in  1  decode writes a register / is a load / is HALT.
REQ-010 d_wsel  in  regbits_t  decode destination register.
REQ-011 flush  in  1  kill the decode instruction (branch or jump redirect).
REQ-012 stall  out  1  hold fetch/decode, inject bubble into entry 0.
REQ-013 fsel_a, fsel_b  out  $clog2(DEPTH+1)  operand source: 0 = register file, k = entry k-1.
REQ-014 busy  out  NREGS  bit r set when any valid entry will write r.
REQ-015 halted  out  1  pipeline drained after HALT.

Function
REQ-016 Entry array: DEPTH entries {valid, wen, load, wsel}; entry 0 youngest (EX), entry DEPTH-1 oldest (WB).
REQ-017 adv=0: all entries hold.
REQ-018 adv=1: entry k shifts to k+1, entry DEPTH-1 retires, entry 0 loads decode if accepted, else a bubble.
REQ-019 Accepted = d_valid & !flush & !stall & state==RUN.
REQ-020 Per operand, the match is the youngest k with valid & wen & wsel==src & src!=0.
REQ-021 No match: fsel=0. Match with load=1 and k<LOAD_STAGE: stall=1. Otherwise fsel=k+1.
REQ-022 stall is the OR of both operands' load-use conditions, gated by d_valid; combinational, same cycle.
REQ-023 Source register 0 always gives fsel=0 and no stall.
REQ-024 busy is the combinational OR over valid wen entries; bit 0 is always 0.
REQ-025 Halt FSM states: RUN, DRAIN, HALTED.
REQ-026 RUN->DRAIN when a d_halt instruction is accepted.
REQ-027 DRAIN: no further issue; stall=1 while d_valid.
REQ-028 DRAIN->HALTED when all entries are invalid.
REQ-029 HALTED is sticky until RST; halted=1 only in HALTED.
REQ-030 Simultaneous flush and d_halt: halt not accepted, state stays RUN.
REQ-031 Simultaneous stall and flush: bubble inserted, no extra penalty.

Reset
REQ-032 RST=1: all entries invalid, state=RUN, stall=0, fsel_a=fsel_b=0, busy=0, halted=0 from the next cycle.
REQ-033 RST mid-DRAIN or mid-stall discards all in-flight state; adv is ignored during the RST cycle.

Structure
REQ-034 regbits_t comes from cpu_types_pkg; scoreboard entry struct and halt-state enum are added to the same package.
REQ-035 One sub-module, fwd_match: priority matcher for one operand, instantiated for rs and rt.

Verification
REQ-036 Back-to-back ALU: write r5 then read r5 -> fsel_a=1 next cycle, stall=0.
REQ-037 Load r8, then dependent add reading r8 in rt (LOAD_STAGE=1) -> stall=1 one cycle, then fsel_b=2.
REQ-038 Two in-flight writes to r3 at entries 0 and 2 -> fsel selects 1 (youngest).
REQ-039 Read r0 while entry 0 writes r0 -> fsel=0, busy[0]=0, stall=0.
REQ-040 HALT accepted with 3 valid entries, adv=1 each cycle -> halted=1 exactly DEPTH cycles later; flush together with HALT -> halted stays 0.
REQ-041 RST asserted during DRAIN -> busy=0, halted=0, state RUN next cycle.
